issue_scoreboard: RTL and testbench

Register-hazard scoreboard between decode and execute. Tracks outstanding writes to each architectural register and gates decode issue with a ready/valid handshake. Decode holds an instruction until `ISSUE_READY`; writeback retires entries. Replaces the single-register `EX_RD_SEL` compare so that multiple instructions can be in flight.

---
 rtl/issue_scoreboard_pkg.sv | 23 ++
 rtl/sb_reg_counter.sv | 44 ++++
 rtl/issue_scoreboard.sv | 130 +++++++++++++
 tb/tb_issue_scoreboard.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared types and defaults for the issue scoreboard
package issue_scoreboard_pkg;

  localparam int SB_XCNT         = 32;
  localparam int SB_RW           = $clog2(SB_XCNT);
  localparam int SB_MAX_INFLIGHT = 4;

  // Decoded instruction as seen by the scoreboard; decode drives this.
  typedef struct packed {
    logic [SB_RW-1:0] rs1;
    logic [SB_RW-1:0] rs2;
    logic [SB_RW-1:0] rd;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
  } sb_issue_t;

  // Register 0 is hardwired zero and never carries a hazard.
  function automatic logic sb_reg_nonzero(input logic [SB_RW-1:0] r);
    return r != '0;
  endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// rtl/sb_reg_counter.sv - up/down/clear saturating counter with zero and max flags
module sb_reg_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         is_zero_o,
  output logic         is_max_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_o     = cnt_q;
  assign is_zero_o = (cnt_q == '0);
  assign is_max_o  = (cnt_q == W'(MAX));

  // Next count: clear wins, simultaneous inc/dec cancel, both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !is_max_o) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && !is_zero_o) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register-hazard scoreboard gating decode issue
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int XCNT         = SB_XCNT,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter bit WB_BYPASS    = 1'b1,
  localparam int RW          = $clog2(XCNT),
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [RW-1:0]   issue_rs1_i,
  input  logic [RW-1:0]   issue_rs2_i,
  input  logic            issue_uses_rs1_i,
  input  logic            issue_uses_rs2_i,
  input  logic [RW-1:0]   issue_rd_i,
  input  logic            issue_writes_rd_i,
  input  logic            wb_valid_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic            flush_i,
  output logic [XCNT-1:0] pending_mask_o,
  output logic [CW-1:0]   inflight_o,
  output logic [31:0]     stall_cycles_o,
  output logic            sb_error_o
);

  sb_issue_t iss;
  assign iss = '{rs1: issue_rs1_i, rs2: issue_rs2_i, rd: issue_rd_i,
                 uses_rs1: issue_uses_rs1_i, uses_rs2: issue_uses_rs2_i,
                 writes_rd: issue_writes_rd_i};

  logic [CW-1:0]   cnt [XCNT];
  logic [XCNT-1:0] zero_vec;
  logic [XCNT-1:0] max_vec;
  logic [XCNT-1:0] busy_vec;
  logic            inflight_max;
  logic            inflight_zero_unused;

  logic        hazard;
  logic        wb_hit;
  logic        full;
  logic        accept_wr;
  logic        wb_retire;
  logic        wb_err;
  logic [31:0] stall_q, stall_d;
  logic        err_q, err_d;

  // x0 never holds a pending write.
  assign cnt[0]      = '0;
  assign zero_vec[0] = 1'b1;
  assign max_vec[0]  = 1'b0;

  // Busy view of each register; with bypass, the last pending write retiring
  // this cycle already counts as done.
  always_comb begin
    for (int r = 0; r < XCNT; r++) begin
      busy_vec[r] = !zero_vec[r];
      if (WB_BYPASS && wb_valid_i && (wb_rd_i == RW'(r)) && (cnt[r] == CW'(1))) begin
        busy_vec[r] = 1'b0;
      end
    end
  end

  // Issue gating: source hazards, per-register full, global full, flush.
  always_comb begin
    hazard = (iss.uses_rs1 && sb_reg_nonzero(iss.rs1) && busy_vec[iss.rs1])
          || (iss.uses_rs2 && sb_reg_nonzero(iss.rs2) && busy_vec[iss.rs2])
          || (iss.writes_rd && sb_reg_nonzero(iss.rd) && max_vec[iss.rd]);
    // A writeback only frees a slot if it actually retires a pending write.
    wb_hit        = wb_valid_i && sb_reg_nonzero(wb_rd_i) && !zero_vec[wb_rd_i];
    wb_err        = wb_valid_i && !flush_i && sb_reg_nonzero(wb_rd_i) && zero_vec[wb_rd_i];
    full          = inflight_max && !wb_hit;
    issue_ready_o = !flush_i && !hazard && !full;
    accept_wr     = issue_valid_i && issue_ready_o && iss.writes_rd && sb_reg_nonzero(iss.rd);
    wb_retire     = wb_hit && !flush_i;
  end

  for (genvar r = 1; r < XCNT; r++) begin : g_reg_cnt
    sb_reg_counter #(.MAX(MAX_INFLIGHT), .W(CW)) u_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (flush_i),
      .inc_i     (accept_wr && (iss.rd == RW'(r))),
      .dec_i     (wb_retire && (wb_rd_i == RW'(r))),
      .cnt_o     (cnt[r]),
      .is_zero_o (zero_vec[r]),
      .is_max_o  (max_vec[r])
    );
  end

  sb_reg_counter #(.MAX(MAX_INFLIGHT), .W(CW)) u_inflight (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (flush_i),
    .inc_i     (accept_wr),
    .dec_i     (wb_retire),
    .cnt_o     (inflight_o),
    .is_zero_o (inflight_zero_unused),
    .is_max_o  (inflight_max)
  );

  assign pending_mask_o = ~zero_vec;

  // Saturating stall count and sticky writeback-underflow flag.
  always_comb begin
    stall_d = stall_q;
    if (issue_valid_i && !issue_ready_o && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    err_d = err_q | wb_err;
  end

  // Status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign sb_error_o     = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  localparam int XCNT = 32;
  localparam int RW   = 5;
  localparam int MAXI = 4;
  localparam int CW   = $clog2(MAXI + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid, u1, u2, wr, wb_valid, flush;
  logic [RW-1:0]   rs1, rs2, rd, wb_rd;
  logic            ready, ready_nb, err, err_nb;
  logic [XCNT-1:0] mask, mask_nb;
  logic [CW-1:0]   inflight, inflight_nb;
  logic [31:0]     stall, stall_nb;

  issue_scoreboard #(.XCNT(XCNT), .MAX_INFLIGHT(MAXI), .WB_BYPASS(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(ready),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_uses_rs1_i(u1), .issue_uses_rs2_i(u2),
    .issue_rd_i(rd), .issue_writes_rd_i(wr), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .flush_i(flush), .pending_mask_o(mask), .inflight_o(inflight),
    .stall_cycles_o(stall), .sb_error_o(err)
  );

  issue_scoreboard #(.XCNT(XCNT), .MAX_INFLIGHT(MAXI), .WB_BYPASS(1'b0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(ready_nb),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_uses_rs1_i(u1), .issue_uses_rs2_i(u2),
    .issue_rd_i(rd), .issue_writes_rd_i(wr), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .flush_i(flush), .pending_mask_o(mask_nb), .inflight_o(inflight_nb),
    .stall_cycles_o(stall_nb), .sb_error_o(err_nb)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              m_cnt [XCNT];
  longint unsigned m_stall;
  bit              m_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending writes per register, totals by summation.
  task automatic m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_stall = 0;
    m_err   = 1'b0;
  endtask

  function automatic int m_inflight();
    int s = 0;
    foreach (m_cnt[i]) s += m_cnt[i];
    return s;
  endfunction

  function automatic bit m_busy(input int r);
    if (m_cnt[r] == 0) return 1'b0;
    if (wb_valid && int'(wb_rd) == r && m_cnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    bit haz, full;
    haz = (u1 && rs1 != 0 && m_busy(int'(rs1)))
       || (u2 && rs2 != 0 && m_busy(int'(rs2)))
       || (wr && rd != 0 && m_cnt[rd] == MAXI);
    full = (m_inflight() == MAXI) && !(wb_valid && wb_rd != 0 && m_cnt[wb_rd] != 0);
    return !flush && !haz && !full;
  endfunction

  function automatic logic [XCNT-1:0] m_mask();
    logic [XCNT-1:0] m = '0;
    for (int r = 1; r < XCNT; r++) m[r] = (m_cnt[r] != 0);
    return m;
  endfunction

  task automatic m_update(input bit rdy);
    if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        if (m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
        else m_err = 1'b1;
      end
      if (issue_valid && rdy && wr && rd != 0) m_cnt[rd]++;
    end
    if (issue_valid && !rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
  endtask

  // One clock: check the bypass DUT against the model, then advance both.
  task automatic step();
    bit r;
    #1;
    r = m_ready();
    check_eq("issue_ready", ready, r);
    check_eq("pending_mask", mask, m_mask());
    check_eq("inflight", inflight, m_inflight());
    check_eq("stall_cycles", stall, m_stall);
    check_eq("sb_error", err, m_err);
    @(posedge clk);
    m_update(r);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; u1 = 0; u2 = 0; wr = 0;
    rs1 = '0; rs2 = '0; rd = '0;
    wb_valid = 0; wb_rd = '0; flush = 0;
  endtask

  task automatic drive_issue(input int r1, input bit e1, input int r2, input bit e2,
                             input int d, input bit w);
    issue_valid = 1; rs1 = RW'(r1); u1 = e1; rs2 = RW'(r2); u2 = e2; rd = RW'(d); wr = w;
  endtask

  task automatic drive_wb(input int r);
    wb_valid = 1; wb_rd = RW'(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int q[$];
    idle();
    m_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_mask", mask, 0);
    check_eq("rst_inflight", inflight, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_error", err, 0);
    @(negedge clk);
    rst_n = 1;

    // ADD x3, x1, x2 then a dependent on x3, with and without bypass
    drive_issue(1, 1, 2, 1, 3, 1);
    #1 check_eq("nb_add_ready", ready_nb, 1);
    step();
    idle();
    check_eq("add_mask", mask, 32'h8);
    check_eq("add_inflight", inflight, 1);
    check_eq("nb_add_mask", mask_nb, 32'h8);
    drive_issue(3, 1, 0, 0, 0, 0);
    repeat (3) begin
      #1 check_eq("nb_dep_stall", ready_nb, 0);
      step();
    end
    check_eq("stall_count", stall, 3);
    drive_wb(3);
    #1;
    check_eq("bypass_ready", ready, 1);
    check_eq("nb_wb_ready", ready_nb, 0);
    step();
    wb_valid = 0;
    #1 check_eq("nb_ready_next", ready_nb, 1);
    step();
    idle();
    step();

    // Four writes to x5 fill both the register and the global budget
    repeat (4) begin
      drive_issue(0, 0, 0, 0, 5, 1);
      step();
    end
    #1 check_eq("x5_fifth_ready", ready, 0);
    step();
    drive_issue(0, 0, 0, 0, 6, 1);
    #1;
    check_eq("x6_full_ready", ready, 0);
    check_eq("inflight_full", inflight, 4);
    step();
    drive_wb(5);
    #1 check_eq("x6_wb_ready", ready, 1);
    step();
    idle();
    check_eq("x5x6_mask", mask, 32'h60);
    check_eq("x5x6_inflight", inflight, 4);
    repeat (3) begin
      drive_wb(5);
      step();
    end
    drive_wb(6);
    step();
    idle();

    // Same-cycle accept and retire of x7
    drive_issue(0, 0, 0, 0, 7, 1);
    step();
    drive_wb(7);
    #1 check_eq("x7_pair_ready", ready, 1);
    step();
    idle();
    check_eq("x7_inflight", inflight, 1);
    check_eq("x7_mask", mask, 32'h80);
    drive_wb(7);
    step();
    idle();

    // Flush with pending x1, x2, x4 and a simultaneous issue
    foreach (q[i]) q.delete(i);
    q = '{1, 2, 4};
    foreach (q[i]) begin
      drive_issue(0, 0, 0, 0, q[i], 1);
      step();
    end
    drive_issue(0, 0, 0, 0, 8, 1);
    flush = 1;
    #1 check_eq("flush_ready", ready, 0);
    step();
    idle();
    check_eq("flush_mask", mask, 0);
    check_eq("flush_inflight", inflight, 0);

    // Writeback to an idle register is a sticky error
    drive_wb(9);
    step();
    idle();
    check_eq("wb_err_set", err, 1);
    repeat (3) step();
    check_eq("wb_err_sticky", err, 1);

    // Writes to x0 never change state
    repeat (3) begin
      drive_issue(0, 0, 0, 0, 0, 1);
      step();
    end
    idle();
    check_eq("x0_inflight", inflight, 0);
    check_eq("x0_mask", mask, 0);

    // Asynchronous reset with x3 pending
    drive_issue(0, 0, 0, 0, 3, 1);
    step();
    idle();
    check_eq("pre_rst_mask", mask, 32'h8);
    #2 rst_n = 0;
    #1;
    check_eq("async_rst_mask", mask, 0);
    check_eq("async_rst_inflight", inflight, 0);
    check_eq("async_rst_error", err, 0);
    check_eq("async_rst_stall", stall, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(31) == 0) flush = 1;
      if ($urandom_range(3) != 0)
        drive_issue(int'($urandom_range(7)), 1'($urandom_range(1)),
                    int'($urandom_range(7)), 1'($urandom_range(1)),
                    int'($urandom_range(7)), 1'($urandom_range(1)));
      q.delete();
      for (int r = 1; r < XCNT; r++) if (m_cnt[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(1) == 1)
        drive_wb(q[$urandom_range(q.size() - 1)]);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
